// File: rtl/mem_program_loader_pkg.sv
// Shared definitions for the byte-stream program loader.
// Frame marker and FSM state encoding.
package mem_program_loader_pkg;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_CNT_H,
    S_CNT_L,
    S_DATA_H,
    S_DATA_L,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/mem_program_loader.sv
// Framed byte-stream loader: assembles big-endian words and drives
// the memory write port while holding the CPU.
module mem_program_loader
  import mem_program_loader_pkg::*;
#(
  parameter int N_ELEMENTS = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_w_en,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(N_ELEMENTS);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            csum_q, csum_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                  acc;
  logic [15:0]           cnt_full;
  logic [ADDR_WIDTH:0]   end_addr;

  assign acc      = in_valid && in_ready;
  assign cnt_full = {cnt_q[15:8], in_data};
  // Range check done one bit wider so addr+cnt cannot wrap.
  assign end_addr = {1'b0, addr_q} + (ADDR_WIDTH+1)'(cnt_full);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (acc) begin
      unique case (state_q)
        S_IDLE, S_ERR: begin
          if (in_data == LOADER_SYNC) begin
            state_d = S_ADDR_H;
            csum_d  = 8'h00;
          end
        end
        S_ADDR_H: begin
          addr_d  = ADDR_WIDTH'({in_data, 8'h00});
          csum_d  = csum_q + in_data;
          state_d = S_ADDR_L;
        end
        S_ADDR_L: begin
          addr_d  = addr_q | ADDR_WIDTH'(in_data);
          csum_d  = csum_q + in_data;
          state_d = S_CNT_H;
        end
        S_CNT_H: begin
          cnt_d   = {in_data, 8'h00};
          csum_d  = csum_q + in_data;
          state_d = S_CNT_L;
        end
        S_CNT_L: begin
          cnt_d  = cnt_full;
          csum_d = csum_q + in_data;
          if (end_addr > LIMIT)  state_d = S_ERR;
          else if (cnt_full == 16'd0) state_d = S_CSUM;
          else state_d = S_DATA_H;
        end
        S_DATA_H: begin
          hi_d    = in_data;
          csum_d  = csum_q + in_data;
          state_d = S_DATA_L;
        end
        S_DATA_L: begin
          csum_d    = csum_q + in_data;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = DATA_WIDTH'({hi_q, in_data});
          addr_d    = addr_q + 1'b1;
          cnt_d     = cnt_q - 16'd1;
          state_d   = (cnt_q == 16'd1) ? S_CSUM : S_DATA_H;
        end
        S_CSUM: state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        default: state_d = state_q;
      endcase
    end
    if (state_q == S_DONE) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      csum_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready   = (state_q != S_DONE);
  assign cpu_hold   = (state_q != S_IDLE) && (state_q != S_ERR);
  assign load_done  = (state_q == S_DONE);
  assign load_err   = (state_q == S_ERR);
  assign mem_w_en   = wr_en_q;
  assign mem_w_addr = wr_addr_q;
  assign mem_w_data = wr_data_q;

endmodule

// File: tb/tb_mem_program_loader.sv
// Bench for mem_program_loader: frame-level reference model,
// directed frames plus randomized frames, gaps and preambles.
module tb_mem_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_w_en;
  logic [15:0] mem_w_addr;
  logic [15:0] mem_w_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  mem_program_loader #(
    .N_ELEMENTS(128), .ADDR_WIDTH(16), .DATA_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int edge_i;
  } wr_t;

  int  errors = 0;
  int  checks = 0;
  int  edge_n = 0;
  int  gap_max = 0;
  int  done_edge = -1;
  wr_t exp_q[$];

  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               name, act, exp, edge_n);
    end
  endtask

  // Every write and done pulse must match a model prediction.
  always @(negedge clk) begin
    if (mem_w_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_w_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 32'(mem_w_addr), 32'(w.addr));
        chk("wr_data", 32'(mem_w_data), 32'(w.data));
        chk("wr_time", 32'(edge_n), 32'(w.edge_i));
      end
    end
    if (load_done === 1'b1)
      chk("done_time", 32'(edge_n), 32'(done_edge));
  end

  task automatic idle_gap();
    repeat ($urandom_range(0, gap_max)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc_edge);
    int n;
    idle_gap();
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 8) begin
        chk("ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_edge = edge_n;
  endtask

  function automatic logic [7:0] frame_csum(input int addr,
                                            input logic [15:0] w[$]);
    int s;
    s = (addr >> 8) + (addr & 255) + (w.size() >> 8) + (w.size() & 255);
    foreach (w[i]) s += (w[i] >> 8) + (w[i] & 16'hFF);
    return 8'(s);
  endfunction

  task automatic check_idle_after(input string tag);
    @(posedge clk); #1;
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_frame(input int addr, input logic [15:0] w[$],
                            input bit bad);
    int          e;
    int          cnt;
    logic [7:0]  cs;
    logic [7:0]  hdr[4];
    cnt = w.size();
    hdr[0] = 8'(addr >> 8);
    hdr[1] = 8'(addr);
    hdr[2] = 8'(cnt >> 8);
    hdr[3] = 8'(cnt);
    send_byte(8'hA5, e);
    chk("hold_after_sync", 32'(cpu_hold), 32'd1);
    chk("err_clear_on_sync", 32'(load_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_byte(hdr[i], e);
      if (i < 3) chk("hold_hdr", 32'(cpu_hold), 32'd1);
    end
    if (addr + cnt > 128) begin
      chk("range_err", 32'(load_err), 32'd1);
      chk("range_hold", 32'(cpu_hold), 32'd0);
      chk("range_ready", 32'(in_ready), 32'd1);
      check_idle_after("range");
      return;
    end
    chk("hold_cnt", 32'(cpu_hold), 32'd1);
    foreach (w[i]) begin
      wr_t x;
      send_byte(w[i][15:8], e);
      chk("hold_data", 32'(cpu_hold), 32'd1);
      send_byte(w[i][7:0], e);
      x.addr   = addr + i;
      x.data   = int'(w[i]);
      x.edge_i = e;
      exp_q.push_back(x);
    end
    cs = frame_csum(addr, w);
    if (bad) cs = cs ^ 8'h01;
    idle_gap();
    in_valid = 1'b1;
    in_data  = cs;
    @(negedge clk);
    done_edge = edge_n + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!bad) begin
      chk("done_pulse", 32'(load_done), 32'd1);
      chk("done_hold", 32'(cpu_hold), 32'd1);
      chk("done_ready", 32'(in_ready), 32'd0);
      chk("done_err", 32'(load_err), 32'd0);
      @(posedge clk); #1;
      chk("post_done", 32'(load_done), 32'd0);
      chk("post_hold", 32'(cpu_hold), 32'd0);
      chk("post_ready", 32'(in_ready), 32'd1);
    end else begin
      chk("csum_err", 32'(load_err), 32'd1);
      chk("csum_hold", 32'(cpu_hold), 32'd0);
      chk("csum_nodone", 32'(load_done), 32'd0);
    end
    check_idle_after("frame");
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_wen"}, 32'(mem_w_en), 32'd0);
    chk({tag, "_waddr"}, 32'(mem_w_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_w_data), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    logic [15:0] t1[$];
    logic [15:0] t3[$];
    logic [15:0] w[$];
    logic [15:0] none[$];
    int          e;
    logic [7:0]  pre[3];

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    t1 = '{16'h1234, 16'h5678, 16'h9ABC};
    chk("model_csum_t1", 32'(frame_csum(16'h0010, t1)), 32'h7D);
    send_frame(16'h0010, t1, 1'b0);

    send_frame(16'h0010, t1, 1'b1);

    t3 = '{16'hDEAD, 16'hBEEF, 16'h0001};
    send_frame(16'h007E, t3, 1'b0);
    t3 = '{16'hDEAD, 16'hBEEF};
    send_frame(16'h007E, t3, 1'b0);

    pre = '{8'h00, 8'hFF, 8'h5A};
    gap_max = 3;
    foreach (pre[i]) begin
      send_byte(pre[i], e);
      chk("preamble_hold", 32'(cpu_hold), 32'd0);
    end
    send_frame(16'h0010, t1, 1'b0);
    gap_max = 0;

    chk("model_csum_zero", 32'(frame_csum(16'h0005, none)), 32'h05);
    send_frame(16'h0005, none, 1'b0);

    send_byte(8'hA5, e);
    send_byte(8'h00, e);
    send_byte(8'h10, e);
    send_byte(8'h00, e);
    send_byte(8'h03, e);
    send_byte(8'h12, e);
    in_valid = 1'b1;
    in_data  = 8'h34;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check_reset_values("midrst");
    check_idle_after("midrst");
    send_frame(16'h0010, t1, 1'b0);
    send_frame(16'h0020, t1, 1'b1);
    send_frame(16'h0010, t1, 1'b0);

    for (int f = 0; f < 40; f++) begin
      int a;
      int n;
      int kind;
      gap_max = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h3C;
        send_byte(b, e);
      end
      kind = $urandom_range(0, 99);
      w.delete();
      if (kind < 15) begin
        a = $urandom_range(0, 16'hFFFF);
        n = (a > 127) ? $urandom_range(0, 3) : 129 - a + $urandom_range(0, 3);
        if (a + n <= 128) n = 129;
      end else begin
        a = $urandom_range(0, 127);
        n = $urandom_range(0, 6);
        if (a + n > 128) n = 128 - a;
      end
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      send_frame(a, w, ($urandom_range(0, 4) == 0));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
